// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared types and constants for the SPI arbiter
//
// Purpose: FSM state encoding, requester identifiers and the abort response
// word used by spi_arb and its testbench.
// Ports: none (package).
package segway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_INERT = 1'b0,
    REQ_A2D   = 1'b1
  } req_id_e;

  // Response returned to a requester whose transaction was aborted.
  localparam logic [15:0] RSP_ABORT = 16'hFFFF;

endpackage

// File: rtl/spi_arb_tmo.sv
// rtl/spi_arb_tmo.sv - transfer timeout counter for spi_arb
//
// Purpose: counts cycles spent waiting for the SPI monarch; flags expiry when
// the count reaches TMO_CYC-1. Only instantiated when SPI_ARB_TIMEOUT_EN is set.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   clr     in  restart count from zero (has priority over en)
//   en      in  advance count by one
//   expired out count has reached TMO_CYC-1
module spi_arb_tmo #(
  parameter int TMO_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (clr) begin
      r_cnt <= 16'd0;
    end else if (en) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign expired = (r_cnt == 16'(TMO_CYC - 1));

endmodule

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - round-robin arbiter sharing one SPI monarch between two requesters
//
// Purpose: grants the inertial or A2D requester one SPI transaction at a time,
// forwards its command, and returns the read data with a one-cycle done pulse.
// Optional transfer timeout is built when macro SPI_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_inert, cmd_inert    inertial request (held until done_inert) and command
//   req_a2d, cmd_a2d        A2D request (held until done_a2d) and command
//   wrt, cmd                start strobe and registered command to SPI monarch
//   done, rd_data           SPI monarch completion pulse and read data
//   rspns                   registered response to the granted requester
//   done_inert, done_a2d    one-cycle completion pulses per requester
//   busy                    arbiter not in IDLE
//   tmo_err                 sticky timeout abort flag (0 without timeout build)
module spi_arb
  import segway_pkg::*;
#(
  parameter int TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_inert,
  input  logic [15:0] cmd_inert,
  input  logic        req_a2d,
  input  logic [15:0] cmd_a2d,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [15:0] rspns,
  output logic        done_inert,
  output logic        done_a2d,
  output logic        busy,
  output logic        tmo_err
);

  arb_state_e  r_state;
  req_id_e     r_last;
  req_id_e     r_gnt;
  logic        r_wrt;
  logic [15:0] r_cmd;
  logic [15:0] r_rspns;
  logic        r_done_inert;
  logic        r_done_a2d;

  logic        w_any_req;
  logic        w_grant;
  req_id_e     w_pick;
  logic        w_tmo_hit;

  assign w_any_req = req_inert | req_a2d;
  assign w_grant   = (r_state == ST_IDLE) & w_any_req;
  // A2D wins when alone, or on a tie when inertial had the previous grant.
  assign w_pick    = (req_a2d & (~req_inert | (r_last == REQ_INERT))) ? REQ_A2D : REQ_INERT;

`ifdef SPI_ARB_TIMEOUT_EN
  logic w_expired;
  logic r_tmo_err;

  spi_arb_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_grant),
    .en      (r_state == ST_XFER),
    .expired (w_expired)
  );

  // A done arriving on the expiry cycle takes precedence over the abort.
  assign w_tmo_hit = w_expired & ~done;
  assign tmo_err   = r_tmo_err;
`else
  // TMO_CYC and RSP_ABORT only matter in the timeout build.
  logic w_tmo_unused;
  assign w_tmo_unused = ^{16'(TMO_CYC), RSP_ABORT};
  assign w_tmo_hit    = 1'b0;
  assign tmo_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last       <= REQ_A2D;
      r_gnt        <= REQ_INERT;
      r_wrt        <= 1'b0;
      r_cmd        <= 16'h0000;
      r_rspns      <= 16'h0000;
      r_done_inert <= 1'b0;
      r_done_a2d   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_tmo_err    <= 1'b0;
`endif
    end else begin
      r_wrt        <= 1'b0;
      r_done_inert <= 1'b0;
      r_done_a2d   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_pick;
            r_last  <= w_pick;
            r_cmd   <= (w_pick == REQ_A2D) ? cmd_a2d : cmd_inert;
            r_wrt   <= 1'b1;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (done) begin
            r_rspns      <= rd_data;
            r_done_inert <= (r_gnt == REQ_INERT);
            r_done_a2d   <= (r_gnt == REQ_A2D);
            r_state      <= ST_RESP;
          end else if (w_tmo_hit) begin
`ifdef SPI_ARB_TIMEOUT_EN
            r_rspns      <= RSP_ABORT;
            r_tmo_err    <= 1'b1;
`endif
            r_done_inert <= (r_gnt == REQ_INERT);
            r_done_a2d   <= (r_gnt == REQ_A2D);
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wrt        = r_wrt;
  assign cmd        = r_cmd;
  assign rspns      = r_rspns;
  assign done_inert = r_done_inert;
  assign done_a2d   = r_done_a2d;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - self-checking testbench for spi_arb
module tb_spi_arb;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        req_inert;
  logic [15:0] cmd_inert;
  logic        req_a2d;
  logic [15:0] cmd_a2d;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [15:0] rspns;
  logic        done_inert;
  logic        done_a2d;
  logic        busy;
  logic        tmo_err;

  spi_arb #(.TMO_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_inert  (req_inert),
    .cmd_inert  (cmd_inert),
    .req_a2d    (req_a2d),
    .cmd_a2d    (cmd_a2d),
    .wrt        (wrt),
    .cmd        (cmd),
    .done       (done),
    .rd_data    (rd_data),
    .rspns      (rspns),
    .done_inert (done_inert),
    .done_a2d   (done_a2d),
    .busy       (busy),
    .tmo_err    (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        a2d;
    logic [15:0] rsp;
  } sb_t;

  sb_t sbq[$];
  sb_t mon_e;

  typedef struct {
    logic        ri;
    logic [15:0] ci;
    logic        ra;
    logic [15:0] ca;
    int          dly;
    logic [15:0] rd;
    logic        exp_a2d;
    logic [15:0] exp_cmd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (done_inert || done_a2d) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {30'b0, done_a2d, done_inert}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_who", {30'b0, done_a2d, done_inert}, mon_e.a2d ? 32'd2 : 32'd1);
        chk("sb_rspns", {16'b0, rspns}, {16'b0, mon_e.rsp});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; req_inert = 1'b0; req_a2d = 1'b0; done = 1'b0; rd_data = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_wrt(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (wrt) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("wrt_timeout", 32'd0, 32'd1);
  endtask

  // Called at the negedge where wrt was seen; done is driven dly cycles later.
  task automatic finish_xfer(input logic a2d, input logic [15:0] rd, input int dly);
    sb_t  s;
    logic stray;
    @(negedge clk);
    chk("wrt_one_cycle", {31'b0, wrt}, 32'd0);
    stray = 1'b0;
    for (int k = 1; k < dly; k++) begin
      @(negedge clk);
      stray = stray | wrt;
    end
    chk("no_extra_wrt", {31'b0, stray}, 32'd0);
    chk("busy_xfer", {31'b0, busy}, 32'd1);
    done = 1'b1; rd_data = rd;
    s.a2d = a2d; s.rsp = rd;
    sbq.push_back(s);
    @(negedge clk);
    done = 1'b0; rd_data = 16'h0;
    chk("done_lat", {31'b0, done_inert | done_a2d}, 32'd1);
    chk("busy_resp", {31'b0, busy}, 32'd1);
  endtask

  initial begin
    int   lat;
    sb_t  s;
    logic [15:0] keep;

    rst_n = 1'b0; req_inert = 1'b0; req_a2d = 1'b0;
    cmd_inert = 16'h0; cmd_a2d = 16'h0; done = 1'b0; rd_data = 16'h0;

    //           ri    ci        ra    ca        dly rd        a2d   cmd
    tbl[0] = '{1'b1, 16'hA5A5, 1'b0, 16'h0000, 20, 16'h1234, 1'b0, 16'hA5A5};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 16'h1111,  3, 16'hBEEF, 1'b1, 16'h1111};
    tbl[2] = '{1'b1, 16'h2222, 1'b1, 16'h3333,  2, 16'h0001, 1'b0, 16'h2222};
    tbl[3] = '{1'b1, 16'h4444, 1'b1, 16'h5555,  1, 16'h8000, 1'b1, 16'h5555};
    tbl[4] = '{1'b1, 16'h6666, 1'b1, 16'h7777,  4, 16'h7FFE, 1'b0, 16'h6666};
    tbl[5] = '{1'b1, 16'h8888, 1'b0, 16'h9999,  2, 16'h0000, 1'b0, 16'h8888};
    tbl[6] = '{1'b1, 16'h9999, 1'b1, 16'hAAAA,  5, 16'hC001, 1'b1, 16'hAAAA};
    tbl[7] = '{1'b0, 16'hFFFF, 1'b1, 16'h0000,  1, 16'hFFFF, 1'b1, 16'h0000};

    do_reset();
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_wrt",   {31'b0, wrt}, 32'd0);
    chk("rst_cmd",   {16'b0, cmd}, 32'd0);
    chk("rst_rspns", {16'b0, rspns}, 32'd0);
    chk("rst_tmo",   {31'b0, tmo_err}, 32'd0);

    // Table of single transactions; round-robin pointer carries between rows.
    for (int i = 0; i < 8; i++) begin
      req_inert = tbl[i].ri; cmd_inert = tbl[i].ci;
      req_a2d   = tbl[i].ra; cmd_a2d   = tbl[i].ca;
      wait_wrt(lat);
      chk($sformatf("v%0d_wrt_lat", i), lat, 32'd1);
      chk($sformatf("v%0d_cmd", i), {16'b0, cmd}, {16'b0, tbl[i].exp_cmd});
      finish_xfer(tbl[i].exp_a2d, tbl[i].rd, tbl[i].dly);
      req_inert = 1'b0; req_a2d = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {31'b0, busy}, 32'd0);
    end

    // Both held continuously from reset: grants alternate, one idle cycle between.
    do_reset();
    req_inert = 1'b1; cmd_inert = 16'h1000;
    req_a2d   = 1'b1; cmd_a2d   = 16'h2000;
    for (int t = 0; t < 4; t++) begin
      wait_wrt(lat);
      chk($sformatf("rr%0d_lat", t), lat, (t == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_cmd", t), {16'b0, cmd}, (t % 2 == 1) ? 32'h2000 : 32'h1000);
      finish_xfer(t % 2 == 1, 16'h0100 + 16'(t), 3);
    end
    req_inert = 1'b0; req_a2d = 1'b0;
    @(negedge clk);

    // A2D arrives mid inertial transfer; req/cmd changes must not disturb it.
    do_reset();
    req_inert = 1'b1; cmd_inert = 16'hA5A5;
    wait_wrt(lat);
    req_a2d = 1'b1; cmd_a2d = 16'h5A5A; cmd_inert = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_cmd_hold", {16'b0, cmd}, 32'hA5A5);
      chk("mid_no_wrt", {31'b0, wrt}, 32'd0);
    end
    finish_xfer(1'b0, 16'hC3C3, 1);
    req_inert = 1'b0;
    chk("mid_cmd_until_done", {16'b0, cmd}, 32'hA5A5);
    wait_wrt(lat);
    chk("mid_a2d_lat", lat, 32'd2);
    chk("mid_a2d_cmd", {16'b0, cmd}, 32'h5A5A);
    finish_xfer(1'b1, 16'h3C3C, 2);
    req_a2d = 1'b0;
    // done held into RESP must be ignored.
    done = 1'b1; rd_data = 16'hBAD0;
    @(negedge clk);
    done = 1'b0;
    chk("resp_done_ignored", {16'b0, rspns}, 32'h3C3C);
    chk("resp_to_idle", {31'b0, busy}, 32'd0);
    // done in IDLE must be ignored.
    done = 1'b1; rd_data = 16'hBAD1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", {16'b0, rspns}, 32'h3C3C);
    chk("idle_done_busy", {31'b0, busy}, 32'd0);

    // Reset 5 cycles into XFER aborts silently.
    req_inert = 1'b1; cmd_inert = 16'h7777;
    wait_wrt(lat);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; req_inert = 1'b0;
    @(negedge clk);
    chk("xrst_busy",  {31'b0, busy}, 32'd0);
    chk("xrst_wrt",   {31'b0, wrt}, 32'd0);
    chk("xrst_cmd",   {16'b0, cmd}, 32'd0);
    chk("xrst_rspns", {16'b0, rspns}, 32'd0);
    chk("xrst_done",  {30'b0, done_a2d, done_inert}, 32'd0);
    chk("xrst_tmo",   {31'b0, tmo_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    done = 1'b1; rd_data = 16'hDEAD;
    @(negedge clk);
    done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("xrst_late_done", {30'b0, done_a2d, done_inert}, 32'd0);
      @(negedge clk);
    end
    chk("xrst_late_rspns", {16'b0, rspns}, 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Timeout abort after TMO cycles, sticky error.
    do_reset();
    req_inert = 1'b1; cmd_inert = 16'h1111;
    wait_wrt(lat);
    s.a2d = 1'b0; s.rsp = 16'hFFFF;
    sbq.push_back(s);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_inert || done_a2d) begin
        lat = k;
        break;
      end
    end
    req_inert = 1'b0;
    chk("tmo_lat", lat, TMO);
    chk("tmo_err_set", {31'b0, tmo_err}, 32'd1);
    @(negedge clk);
    req_a2d = 1'b1; cmd_a2d = 16'h2222;
    wait_wrt(lat);
    finish_xfer(1'b1, 16'h2222, 3);
    req_a2d = 1'b0;
    chk("tmo_err_sticky", {31'b0, tmo_err}, 32'd1);
    @(negedge clk);

    // done on the expiry cycle wins.
    do_reset();
    chk("tie_tmo_clr", {31'b0, tmo_err}, 32'd0);
    req_inert = 1'b1; cmd_inert = 16'h3333;
    wait_wrt(lat);
    repeat (TMO - 1) @(negedge clk);
    done = 1'b1; rd_data = 16'h0F0F;
    s.a2d = 1'b0; s.rsp = 16'h0F0F;
    sbq.push_back(s);
    @(negedge clk);
    done = 1'b0;
    req_inert = 1'b0;
    chk("tie_done", {31'b0, done_inert}, 32'd1);
    chk("tie_tmo_err", {31'b0, tmo_err}, 32'd0);
    @(negedge clk);
`else
    // Without the timeout build XFER waits indefinitely.
    do_reset();
    req_inert = 1'b1; cmd_inert = 16'h1111;
    wait_wrt(lat);
    keep = 16'h0;
    repeat (200) @(negedge clk);
    chk("notmo_busy", {31'b0, busy}, 32'd1);
    chk("notmo_err", {31'b0, tmo_err}, 32'd0);
    chk("notmo_rspns", {16'b0, rspns}, {16'b0, keep});
    finish_xfer(1'b0, 16'h5555, 1);
    req_inert = 1'b0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
